// File: rtl/dot_product_scheduler.sv
// Issues the 64 row/column operand pairs of an 8x8 matrix product to a shared
// dot-product unit and writes the in-order results back by index k = i*8+j.
module dot_product_scheduler #(
   parameter int unsigned MAX_OUTSTANDING = 32,
   parameter int unsigned TIMEOUT         = 256
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   output logic         busy,
   output logic         done,
   output logic         error,
   output logic         a_rd_en,
   output logic [2:0]   a_addr,
   input  logic [255:0] a_rdata,
   output logic         b_rd_en,
   output logic [2:0]   b_addr,
   input  logic [255:0] b_rdata,
   output logic [255:0] dp_row,
   output logic [255:0] dp_column,
   output logic         dp_validin,
   input  logic [31:0]  dp_out,
   input  logic         dp_validity,
   output logic         res_we,
   output logic [5:0]   res_addr,
   output logic [31:0]  res_data
);

   localparam int unsigned NUM_PAIRS = 64;
   localparam int unsigned IDX_W     = 7;
   localparam int unsigned OUT_W     = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned WD_W      = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, ERROR} state_t;

   state_t             state, state_d;
   logic [IDX_W-1:0]   issue_idx, result_idx;
   logic [OUT_W-1:0]   outstanding;
   logic [WD_W-1:0]    wd_cnt;
   logic               launch_c, issue_c, accept_c, timeout_c;

   // Operands go straight from the buffers to the dot-product unit.
   assign dp_row    = a_rdata;
   assign dp_column = b_rdata;
   assign b_rd_en   = a_rd_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   // Next state plus the per-cycle issue / accept / timeout decisions.
   always_comb begin
      state_d   = state;
      launch_c  = 1'b0;
      issue_c   = 1'b0;
      accept_c  = 1'b0;
      timeout_c = 1'b0;
      case (state)
         IDLE, ERROR: begin
            if (start) begin
               launch_c = 1'b1;
               issue_c  = 1'b1;
               state_d  = ISSUE;
            end
         end
         ISSUE, DRAIN: begin
            accept_c  = dp_validity && (outstanding != '0);
            timeout_c = (outstanding != '0) && !dp_validity &&
                        (wd_cnt == WD_W'(TIMEOUT - 1));
            if (timeout_c) begin
               state_d = ERROR;
            end else if (state == ISSUE) begin
               issue_c = (outstanding != OUT_W'(MAX_OUTSTANDING));
               if (issue_c && (issue_idx == IDX_W'(NUM_PAIRS - 1))) state_d = DRAIN;
            end else if (accept_c && (result_idx == IDX_W'(NUM_PAIRS - 1))) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         a_rd_en     <= 1'b0;
         a_addr      <= 3'd0;
         b_addr      <= 3'd0;
         dp_validin  <= 1'b0;
         res_we      <= 1'b0;
         res_addr    <= 6'd0;
         res_data    <= 32'd0;
         issue_idx   <= '0;
         result_idx  <= '0;
         outstanding <= '0;
         wd_cnt      <= '0;
      end else begin
         a_rd_en    <= issue_c;
         dp_validin <= a_rd_en;
         res_we     <= accept_c;
         done       <= accept_c && (result_idx == IDX_W'(NUM_PAIRS - 1));
         busy       <= (state_d == ISSUE) || (state_d == DRAIN);

         if (launch_c)       error <= 1'b0;
         else if (timeout_c) error <= 1'b1;

         // A launch issues pair 0 in the same cycle the counters are cleared.
         if (issue_c) begin
            a_addr    <= launch_c ? 3'd0 : issue_idx[5:3];
            b_addr    <= launch_c ? 3'd0 : issue_idx[2:0];
            issue_idx <= launch_c ? IDX_W'(1) : issue_idx + IDX_W'(1);
         end

         if (launch_c)      result_idx <= '0;
         else if (accept_c) result_idx <= result_idx + IDX_W'(1);

         if (accept_c) begin
            res_addr <= result_idx[5:0];
            res_data <= dp_out;
         end

         if (launch_c) begin
            outstanding <= OUT_W'(1);
         end else begin
            case ({issue_c, accept_c})
               2'b10:   outstanding <= outstanding + OUT_W'(1);
               2'b01:   outstanding <= outstanding - OUT_W'(1);
               default: outstanding <= outstanding;
            endcase
         end

         // Watchdog: idle cycles while results are owed; any result restarts it.
         if (launch_c) begin
            wd_cnt <= '0;
         end else if ((state == ISSUE) || (state == DRAIN)) begin
            if (dp_validity)             wd_cnt <= '0;
            else if (outstanding != '0)  wd_cnt <= wd_cnt + WD_W'(1);
         end
      end
   end

endmodule
